// File: rtl/da_mac_engine_if.sv
// Handshake/data bundle between the FIR control FSM (master) and the DA MAC engine (slave).
// Optional macro DA_STALL_EN adds the out_ready back-pressure signal.
interface da_mac_engine_if #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8
);
  localparam int OW = DW + CW + $clog2(TAPS);

  logic                   coef_load;
  logic signed [CW-1:0]   coef_in;
  logic                   start;
  logic [TAPS*DW-1:0]     taps_in;
  logic                   ready;
  logic                   busy;
  logic                   y_valid;
  logic signed [OW-1:0]   y_out;
`ifdef DA_STALL_EN
  logic                   out_ready;
`endif

  modport master (
    output coef_load, coef_in, start, taps_in,
`ifdef DA_STALL_EN
    output out_ready,
`endif
    input  ready, busy, y_valid, y_out
  );

  modport slave (
    input  coef_load, coef_in, start, taps_in,
`ifdef DA_STALL_EN
    input  out_ready,
`endif
    output ready, busy, y_valid, y_out
  );
endinterface

// File: rtl/da_mac_engine.sv
// Bit-serial distributed-arithmetic MAC: y = sum(coef[i] * x[i]), one sample bit per clock, LSB first.
// Optional macro DA_STALL_EN: DONE holds the result until out_ready is seen.
module da_mac_engine #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  da_mac_engine_if.slave  bus
);
  localparam int OW = DW + CW + $clog2(TAPS);
  localparam int PW = CW + $clog2(TAPS) + 1;
  localparam int AW = PW + 1;
  localparam int KW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [KW-1:0] KLAST = KW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [CW-1:0]   coef_q [TAPS];
  logic signed [CW-1:0]   coef_d [TAPS];
  logic [DW-1:0]          x_q    [TAPS];
  logic [DW-1:0]          x_d    [TAPS];
  logic signed [AW-1:0]   r_q, r_d;
  logic [DW-1:0]          l_q, l_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [OW-1:0]   y_q, y_d;

  logic                   ready_s, busy_s, y_valid_s;
  logic signed [PW-1:0]   part;
  logic signed [AW-1:0]   acc_t;
  logic signed [AW-1:0]   r_sh;
  logic [DW-1:0]          l_sh;

  // FSM next state and status outputs
  always_comb begin
    state_d   = state_q;
    ready_s   = 1'b0;
    busy_s    = 1'b0;
    y_valid_s = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_s = 1'b1;
        if (!bus.coef_load && bus.start) state_d = SHIFT;
      end
      SHIFT: begin
        busy_s = 1'b1;
        if (k_q == KLAST) state_d = DONE;
      end
      DONE: begin
        y_valid_s = 1'b1;
`ifdef DA_STALL_EN
        if (bus.out_ready) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Right-shifting accumulator: r holds the upper part, l collects the bits shifted out,
  // so {r, l} after DW steps is the exact sum without needing a full-width adder.
  always_comb begin
    part = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (x_q[i][0]) part = part + PW'(coef_q[i]);
    end
    if (k_q == KLAST) acc_t = r_q - AW'(part);
    else              acc_t = r_q + AW'(part);
    r_sh = acc_t >>> 1;
    l_sh = {acc_t[0], l_q[DW-1:1]};
  end

  always_comb begin
    coef_d = coef_q;
    x_d    = x_q;
    r_d    = r_q;
    l_d    = l_q;
    k_d    = k_q;
    y_d    = y_q;
    unique case (state_q)
      IDLE: begin
        if (bus.coef_load) begin
          for (int i = 0; i < TAPS - 1; i++) coef_d[i] = coef_q[i+1];
          coef_d[TAPS-1] = bus.coef_in;
        end else if (bus.start) begin
          for (int i = 0; i < TAPS; i++) x_d[i] = bus.taps_in[i*DW +: DW];
          r_d = '0;
          l_d = '0;
          k_d = '0;
        end
      end
      SHIFT: begin
        for (int i = 0; i < TAPS; i++) x_d[i] = x_q[i] >> 1;
        r_d = r_sh;
        l_d = l_sh;
        k_d = k_q + KW'(1);
        if (k_q == KLAST) begin
          k_d = '0;
          y_d = OW'({r_sh, l_sh});
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
      end
      r_q <= '0;
      l_q <= '0;
      k_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      x_q     <= x_d;
      r_q     <= r_d;
      l_q     <= l_d;
      k_q     <= k_d;
      y_q     <= y_d;
    end
  end

  assign bus.ready   = ready_s;
  assign bus.busy    = busy_s;
  assign bus.y_valid = y_valid_s;
  assign bus.y_out   = y_q;
endmodule

// File: tb/tb_da_mac_engine.sv
// Self-checking bench for da_mac_engine: directed vector table, corner sequences and random windows.
module tb_da_mac_engine;
  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mcoef [TAPS];

  always #5 clk = ~clk;

  da_mac_engine_if #(.TAPS(TAPS), .DW(DW), .CW(CW)) bus ();

  da_mac_engine #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int c [TAPS];
    int x [TAPS];
    int exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_y(input int x [TAPS]);
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += mcoef[i] * x[i];
    return s;
  endfunction

  task automatic model_shift(input int c);
    for (int i = 0; i < TAPS - 1; i++) mcoef[i] = mcoef[i+1];
    mcoef[TAPS-1] = c;
  endtask

  task automatic load_coefs(input int c [TAPS], input int n);
    for (int i = 0; i < n; i++) begin
      bus.coef_load = 1'b1;
      bus.coef_in   = CW'(c[i]);
      @(negedge clk);
      model_shift(c[i]);
    end
    bus.coef_load = 1'b0;
  endtask

  task automatic set_taps(input int x [TAPS]);
    for (int i = 0; i < TAPS; i++) bus.taps_in[i*DW +: DW] = DW'(x[i]);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.y_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_x(input int x [TAPS], input int exp, input string name);
    int lat;
    set_taps(x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(lat);
    chk({name, " latency"}, lat, DW);
    chk({name, " y_out"}, int'(bus.y_out), exp);
    @(negedge clk);
    chk({name, " pulse width"}, int'(bus.y_valid), 0);
    chk({name, " ready after"}, int'(bus.ready), 1);
  endtask

  initial begin
    int lat;
    int nv;
    int c [TAPS];
    int x [TAPS];

    reset         = 1'b1;
    bus.coef_load = 1'b0;
    bus.coef_in   = '0;
    bus.start     = 1'b0;
    bus.taps_in   = '0;
`ifdef DA_STALL_EN
    bus.out_ready = 1'b1;
`endif
    for (int i = 0; i < TAPS; i++) mcoef[i] = 0;

    vecs[0].c = '{1, 2, 3, 4};         vecs[0].x = '{10, 20, 30, 40};       vecs[0].exp = 300;
    vecs[1].c = '{-1, 2, -3, 4};       vecs[1].x = '{-128, 127, -1, 0};     vecs[1].exp = 385;
    vecs[2].c = '{-1, 2, -3, 4};       vecs[2].x = '{0, 0, 0, 0};           vecs[2].exp = 0;
    vecs[3].c = '{-128, -128, -128, -128}; vecs[3].x = '{-128, -128, -128, -128}; vecs[3].exp = 65536;
    vecs[4].c = '{127, 127, 127, 127}; vecs[4].x = '{-128, -128, -128, -128}; vecs[4].exp = -65024;

    repeat (3) @(negedge clk);
    chk("reset ready", int'(bus.ready), 1);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset y_valid", int'(bus.y_valid), 0);
    chk("reset y_out", int'(bus.y_out), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      load_coefs(vecs[v].c, TAPS);
      run_x(vecs[v].x, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // start and coef_load pulsed while the engine is shifting
    load_coefs(vecs[0].c, TAPS);
    set_taps(vecs[0].x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("shift busy", int'(bus.busy), 1);
    chk("shift ready", int'(bus.ready), 0);
    x = '{5, 5, 5, 5};
    set_taps(x);
    bus.start     = 1'b1;
    bus.coef_load = 1'b1;
    bus.coef_in   = 8'sd99;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.coef_load = 1'b0;
    wait_valid(lat);
    chk("ignored-in-shift y_out", int'(bus.y_out), 300);
    @(negedge clk);
    @(negedge clk);
    chk("ignored start no rerun", int'(bus.busy), 0);
    x = '{1, 1, 1, 1};
    run_x(x, 10, "coefs kept");

    // coef_load and start together in IDLE: load wins
    x = '{3, -7, 11, 2};
    set_taps(x);
    bus.coef_load = 1'b1;
    bus.coef_in   = 8'sd5;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.coef_load = 1'b0;
    bus.start     = 1'b0;
    model_shift(5);
    chk("load+start busy", int'(bus.busy), 0);
    chk("load+start ready", int'(bus.ready), 1);
    run_x(x, model_y(x), "after load+start");

    // reset in the middle of a computation
    x = '{100, -50, 25, -12};
    set_taps(x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) mcoef[i] = 0;
    chk("midreset ready", int'(bus.ready), 1);
    chk("midreset busy", int'(bus.busy), 0);
    chk("midreset y_out", int'(bus.y_out), 0);
    nv = 0;
    for (int i = 0; i < DW + 4; i++) begin
      if (bus.y_valid) nv++;
      @(negedge clk);
    end
    chk("midreset no y_valid", nv, 0);
    x = '{5, 6, 7, 8};
    run_x(x, 0, "cleared coefs");

`ifdef DA_STALL_EN
    load_coefs(vecs[0].c, TAPS);
    set_taps(vecs[0].x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(lat);
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall y_valid", int'(bus.y_valid), 1);
      chk("stall y_out", int'(bus.y_out), 300);
      chk("stall ready", int'(bus.ready), 0);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall release y_valid", int'(bus.y_valid), 0);
    chk("stall release ready", int'(bus.ready), 1);
    chk("stall release busy", int'(bus.busy), 0);
`endif

    // randomized windows with random full or partial coefficient loads
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < TAPS; i++) begin
        c[i] = int'($urandom_range(0, 255)) - 128;
        x[i] = int'($urandom_range(0, 255)) - 128;
      end
      load_coefs(c, int'($urandom_range(1, TAPS)));
      run_x(x, model_y(x), $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
